mux_rr_stream: RTL and testbench
================================

Name: mux_rr_stream

Overview:
- Registered N-channel streaming multiplexer with valid/ready handshakes, round-robin arbitration and optional packet lock.
- Merges SEL per-channel sample streams, e.g. receiver-channel IQ words, onto one shared output toward the CPU/SPI data path.
- Each output word is tagged with its source channel index.
- Adds flow control, fairness and a 1-cycle registered output to static index selection.

Parameters:
- WIDTH, 16, bits per data word.
- SEL, 4, number of input channels (>=1).
- LOCK, 1, 1 = hold grant from first beat until the beat with last is accepted; 0 = re-arbitrate every beat.
- CW, max(1, clog2(SEL)), channel index width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  SEL*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  SEL  per-channel valid.
- in_last  in  SEL  per-channel end-of-packet marker.
- in_ready  out  SEL  per-channel ready; at most one bit high.
- out_data  out  WIDTH  registered output word.
- out_chan  out  CW  source channel of out_data.
- out_last  out  1  last flag of out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0, out_last=0.
  - Round-robin pointer=SEL-1, so channel 0 has first priority.
  - lock=0.
  - in_ready=0 while rst is high.
- Transfer rule: a beat transfers on channel i when in_valid[i] && in_ready[i]. The output side transfers when out_valid && out_ready.
- Advance condition: adv = !out_valid || out_ready. in_ready[i] = adv && grant[i].
- Arbitration (combinational, when not locked):
  - grant = first channel with in_valid set, searching pointer+1, pointer+2, ... modulo SEL.
  - No valid channel: grant=0 and no transfer.
- Pointer update: on every accepted input beat, pointer <= granted index.
- Lock, LOCK=1:
  - On accepting a beat with in_last=0, set lock=1 and hold the grant on that channel.
  - While locked, other channels get in_ready=0 even if the locked channel drops valid; output bubbles.
  - On accepting a beat with in_last=1, clear lock.
  - A single beat with last=1 never locks.
- Lock, LOCK=0: lock is held at 0 and in_last is passed through only.
- Output register:
  - On an accepted input beat, load out_data, out_chan, out_last from the granted channel and set out_valid=1.
  - If out_valid && out_ready and no input is accepted that cycle, clear out_valid. out_data, out_chan and out_last hold their old values.
  - If out_valid && out_ready and an input is accepted the same cycle, reload the register; out_valid stays 1.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Latency: 1 cycle from input acceptance to out_valid.
- Stall: while out_valid && !out_ready, the output register is stable and all in_ready bits are 0.
- Wrap-around: the pointer wraps from SEL-1 to 0. The modulo search is correct for non-power-of-2 SEL.
- SEL=1: grant is always channel 0, out_chan=0, the pointer is a don't-care; the block degenerates to a registered stage.
- Reset mid-packet: lock, pointer and the output register return to their reset values on the next edge. A partially transferred packet is dropped; no recovery is required.

Decomposition:
- Shared include kiwi.gen.vh: the clog2 function, already shared.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr[CW], hold, hold_idx.
  - Output: one-hot grant[N] and index idx[CW].
  - Purely combinational; the pointer register stays in mux_rr_stream.
- No new package constants.

Test Plan:
1. Reset release, SEL=4, all in_valid=0 -> out_valid=0, in_ready=0000 every cycle; out_chan=0.
2. LOCK=0, all four valid with data 0x1000+i, last=1, out_ready=1 -> out_chan sequence 0,1,2,3,0,...; one beat/cycle; first out_valid 1 cycle after first accept.
3. LOCK=1, ch2 sends a 3-beat packet (last on beat 3) while ch0 and ch1 are valid -> out_chan 2,2,2 then 0 then 1; ch2 dropping valid for 2 cycles mid-packet -> 2 bubble cycles, no ch0/ch1 beats inserted.
4. out_ready held 0 for 5 cycles with out_valid=1 -> out_data/out_chan stable, in_ready=0000; after release, no words lost or duplicated (scoreboard count matches).
5. SEL=3, only ch2 and ch0 valid -> order 0,2,0,2 with pointer wrap 2->0; out_chan fits in 2 bits.
6. rst asserted mid-packet under LOCK=1 -> next cycle out_valid=0, lock cleared; after release ch0 is served first.

Source files
------------

// File: rtl/mux_rr_stream_pkg.sv
// Shared types and elaboration helpers for the round-robin stream multiplexer.
package mux_rr_stream_pkg;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A channel index is always at least one bit wide, even for a single channel.
    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// Combinational round-robin arbiter with an optional hold on a fixed index.
module rr_arbiter
    import mux_rr_stream_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = chan_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    input  logic          hold_i,
    input  logic [CW-1:0] hold_idx_i,
    output logic [N-1:0]  grant_o,
    output logic [CW-1:0] idx_o
);

    // The requester closest after ptr (modulo N) has the smallest rank, so no
    // variable-width modulo is needed and non-power-of-2 N works unchanged.
    always_comb begin
        int unsigned p;
        int unsigned rank;
        int unsigned best;
        grant_o = '0;
        idx_o   = '0;
        p       = 32'(ptr_i);
        best    = N + 1;
        rank    = 0;
        if (hold_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (hold_idx_i == CW'(i) && req_i[i]) begin
                    grant_o[i] = 1'b1;
                    idx_o      = CW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                rank = (i > p) ? (i - p) : (i + N - p);
                if (req_i[i] && rank < best) begin
                    best    = rank;
                    grant_o = '0;
                    grant_o[i] = 1'b1;
                    idx_o   = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// Registered N-channel valid/ready stream multiplexer with round-robin
// arbitration, optional packet lock and source-channel tagging.
module mux_rr_stream
    import mux_rr_stream_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned SEL   = 4,
    parameter  int unsigned LOCK  = 1,
    localparam int unsigned CW    = chan_width(SEL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL*WIDTH-1:0] in_data,
    input  logic [SEL-1:0]       in_valid,
    input  logic [SEL-1:0]       in_last,
    output logic [SEL-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [CW-1:0]    ptr_q;
    lock_state_e      lock_q;
    logic [CW-1:0]    lock_idx_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_chan_q;
    logic             out_last_q;
    logic             out_valid_q;

    logic [SEL-1:0]   grant;
    logic [CW-1:0]    grant_idx;
    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] sel_data_d;
    logic             sel_last_d;

    rr_arbiter #(
        .N (SEL)
    ) u_arb (
        .req_i      (in_valid),
        .ptr_i      (ptr_q),
        .hold_i     (lock_q == LK_HELD),
        .hold_idx_i (lock_idx_q),
        .grant_o    (grant),
        .idx_o      (grant_idx)
    );

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (rst || !adv) ? '0 : grant;
    assign accept   = |(in_valid & in_ready);

    always_comb begin
        sel_data_d = '0;
        sel_last_d = 1'b0;
        for (int unsigned i = 0; i < SEL; i++) begin
            if (grant[i]) begin
                sel_data_d = in_data[i*WIDTH +: WIDTH];
                sel_last_d = in_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= CW'(SEL - 1);
            lock_q      <= LK_FREE;
            lock_idx_q  <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            ptr_q       <= grant_idx;
            out_data_q  <= sel_data_d;
            out_chan_q  <= grant_idx;
            out_last_q  <= sel_last_d;
            out_valid_q <= 1'b1;
            case (lock_q)
                LK_FREE: begin
                    if (LOCK != 0 && !sel_last_d) begin
                        lock_q     <= LK_HELD;
                        lock_idx_q <= grant_idx;
                    end
                end
                LK_HELD: begin
                    if (sel_last_d) begin
                        lock_q <= LK_FREE;
                    end
                end
                default: lock_q <= LK_FREE;
            endcase
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_chan_q)));

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream: SEL=4 unlocked, SEL=4 locked and SEL=3 instances.
module tb_mux_rr_stream;

    typedef struct {
        logic [1:0]  chan;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // A: SEL=4, LOCK=0
    logic [63:0] a_in_data = '0;
    logic [3:0]  a_in_valid = '0, a_in_last = '0, a_in_ready;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_chan;
    logic        a_out_last, a_out_valid, a_out_ready = 1'b1;
    // B: SEL=4, LOCK=1
    logic [63:0] b_in_data = '0;
    logic [3:0]  b_in_valid = '0, b_in_last = '0, b_in_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_chan;
    logic        b_out_last, b_out_valid, b_out_ready = 1'b1;
    // C: SEL=3, LOCK=1
    logic [47:0] c_in_data = '0;
    logic [2:0]  c_in_valid = '0, c_in_last = '0, c_in_ready;
    logic [15:0] c_out_data;
    logic [1:0]  c_out_chan;
    logic        c_out_last, c_out_valid, c_out_ready = 1'b1;

    mux_rr_stream #(.WIDTH(16), .SEL(4), .LOCK(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_last(a_in_last), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_chan(a_out_chan), .out_last(a_out_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready));

    mux_rr_stream #(.WIDTH(16), .SEL(4), .LOCK(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_chan(b_out_chan), .out_last(b_out_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready));

    mux_rr_stream #(.WIDTH(16), .SEL(3), .LOCK(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_last(c_in_last), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_chan(c_out_chan), .out_last(c_out_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = '1; b_in_valid = '1; c_in_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_a_ready: got %b expected 0000", a_in_ready); end
        checks++;
        if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_b_ready: got %b expected 0000", b_in_ready); end
        checks++;
        if (c_in_ready !== 3'b000) begin errors++; $display("FAIL reset_c_ready: got %b expected 000", c_in_ready); end
        next_cycle();
        rst = 1'b0;
        a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL idle_a: got valid=%b ready=%b expected valid=0 ready=0000", a_out_valid, a_in_ready);
            end
            checks++;
            if (a_out_chan !== 2'd0 || a_out_data !== 16'h0000 || a_out_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_a_regs: got chan=%0d data=%h last=%b expected 0/0000/0", a_out_chan, a_out_data, a_out_last);
            end
            checks++;
            if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_bc: got b=%b c=%b expected 0 0", b_out_valid, c_out_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_rr_nolock();
        for (int j = 0; j < 8; j++) sb.push_back('{chan: 2'(j % 4), data: 16'(16'h1000 + j % 4), last: 1'b1});
        a_out_ready = 1'b1;
        a_in_last = 4'b1111;
        for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'(16'h1000 + i);
        for (int c = 0; c < 10; c++) begin
            a_in_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (a_in_ready !== 4'(1 << (c % 4))) begin
                    errors++;
                    $display("FAIL rr_ready c%0d: got %b expected %b", c, a_in_ready, 4'(1 << (c % 4)));
                end
            end
            checks++;
            if (a_out_valid !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL rr_out_valid c%0d: got %b expected %b", c, a_out_valid, (c >= 1 && c <= 8));
            end
            if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra: got chan=%0d expected no word", a_out_chan);
                end else begin
                    exp_t e = sb.pop_front();
                    if (a_out_chan !== e.chan || a_out_data !== e.data || a_out_last !== e.last) begin
                        errors++;
                        $display("FAIL rr_word: got %0d/%h/%b expected %0d/%h/%b", a_out_chan, a_out_data, a_out_last, e.chan, e.data, e.last);
                    end
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_lock_packet();
        logic [3:0]  vt  [9] = '{4'b0100, 4'b0111, 4'b0011, 4'b0011, 4'b0111, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
        logic [15:0] d2  [9] = '{16'h2A01, 16'h2A02, 16'h2A02, 16'h2A02, 16'h2A03, 16'h2A03, 16'h2A03, 16'h2A03, 16'h2A03};
        logic        l2  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  irm [9] = '{4'hF, 4'hF, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [3:0]  ire [9] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
        logic        ov  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        sb.push_back('{chan: 2'd2, data: 16'h2A01, last: 1'b0});
        sb.push_back('{chan: 2'd2, data: 16'h2A02, last: 1'b0});
        sb.push_back('{chan: 2'd2, data: 16'h2A03, last: 1'b1});
        sb.push_back('{chan: 2'd0, data: 16'h0A00, last: 1'b1});
        sb.push_back('{chan: 2'd1, data: 16'h1A00, last: 1'b1});
        b_out_ready = 1'b1;
        b_in_data[0*16 +: 16] = 16'h0A00;
        b_in_data[1*16 +: 16] = 16'h1A00;
        b_in_data[3*16 +: 16] = 16'h3A00;
        for (int c = 0; c < 9; c++) begin
            b_in_valid = vt[c];
            b_in_data[2*16 +: 16] = d2[c];
            b_in_last = {1'b1, l2[c], 2'b11};
            @(negedge clk);
            checks++;
            if ((b_in_ready & irm[c]) !== ire[c]) begin
                errors++;
                $display("FAIL lock_ready c%0d: got %b expected %b (mask %b)", c, b_in_ready, ire[c], irm[c]);
            end
            checks++;
            if (b_out_valid !== ov[c]) begin
                errors++;
                $display("FAIL lock_out_valid c%0d: got %b expected %b", c, b_out_valid, ov[c]);
            end
            if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL lock_extra: got chan=%0d expected no word", b_out_chan);
                end else begin
                    exp_t e = sb.pop_front();
                    if (b_out_chan !== e.chan || b_out_data !== e.data || b_out_last !== e.last) begin
                        errors++;
                        $display("FAIL lock_word: got %0d/%h/%b expected %0d/%h/%b", b_out_chan, b_out_data, b_out_last, e.chan, e.data, e.last);
                    end
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL lock_missing: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stall();
        int k[4] = '{0, 0, 0, 0};
        int popped = 0;
        bit done = 0;
        for (int j = 0; j < 8; j++)
            sb.push_back('{chan: 2'(j % 4), data: 16'(16'h4000 + 16 * (j % 4) + j / 4), last: 1'b1});
        a_in_last = 4'b1111;
        for (int c = 0; c < 40 && !done; c++) begin
            a_out_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_in_valid[i] = (k[i] < 2);
                a_in_data[i*16 +: 16] = 16'(16'h4000 + 16 * i + k[i]);
            end
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                checks++;
                if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b1 || a_out_chan !== 2'd1 || a_out_data !== 16'h4010) begin
                    errors++;
                    $display("FAIL stall c%0d: got ready=%b valid=%b chan=%0d data=%h expected 0000/1/1/4010",
                             c, a_in_ready, a_out_valid, a_out_chan, a_out_data);
                end
            end
            if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: got chan=%0d expected no word", a_out_chan);
                end else begin
                    exp_t e = sb.pop_front();
                    popped++;
                    if (a_out_chan !== e.chan || a_out_data !== e.data || a_out_last !== e.last) begin
                        errors++;
                        $display("FAIL stall_word: got %0d/%h/%b expected %0d/%h/%b", a_out_chan, a_out_data, a_out_last, e.chan, e.data, e.last);
                    end
                end
                if (popped == 8) done = 1;
            end
            for (int i = 0; i < 4; i++) if (a_in_valid[i] && a_in_ready[i]) k[i]++;
            next_cycle();
        end
        checks++;
        if (!done) begin errors++; $display("FAIL stall_timeout: got %0d words expected 8", popped); sb.delete(); end
        a_in_valid = '0;
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: got valid=%b expected 0", a_out_valid); end
        next_cycle();
    endtask

    task automatic test_wrap_sel3();
        sb.push_back('{chan: 2'd0, data: 16'h3000, last: 1'b1});
        sb.push_back('{chan: 2'd2, data: 16'h3002, last: 1'b1});
        sb.push_back('{chan: 2'd0, data: 16'h3000, last: 1'b1});
        sb.push_back('{chan: 2'd2, data: 16'h3002, last: 1'b1});
        c_out_ready = 1'b1;
        c_in_last = 3'b111;
        for (int i = 0; i < 3; i++) c_in_data[i*16 +: 16] = 16'(16'h3000 + i);
        for (int c = 0; c < 6; c++) begin
            c_in_valid = (c < 4) ? 3'b101 : 3'b000;
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (c_in_ready !== ((c % 2 == 0) ? 3'b001 : 3'b100)) begin
                    errors++;
                    $display("FAIL wrap_ready c%0d: got %b expected %b", c, c_in_ready, (c % 2 == 0) ? 3'b001 : 3'b100);
                end
            end
            checks++;
            if (c_out_valid !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL wrap_out_valid c%0d: got %b expected %b", c, c_out_valid, (c >= 1 && c <= 4));
            end
            if (c_out_valid === 1'b1 && c_out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra: got chan=%0d expected no word", c_out_chan);
                end else begin
                    exp_t e = sb.pop_front();
                    if (c_out_chan !== e.chan || c_out_data !== e.data || c_out_last !== e.last) begin
                        errors++;
                        $display("FAIL wrap_word: got %0d/%h/%b expected %0d/%h/%b", c_out_chan, c_out_data, c_out_last, e.chan, e.data, e.last);
                    end
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d left expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_midpacket();
        b_out_ready = 1'b1;
        b_in_data[0*16 +: 16] = 16'h0B00;
        b_in_data[3*16 +: 16] = 16'h3B01;
        b_in_last = 4'b0111;
        b_in_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (b_in_ready !== 4'b1000) begin errors++; $display("FAIL mid_start: got %b expected 1000", b_in_ready); end
        next_cycle();
        rst = 1'b1;
        b_in_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (b_in_ready !== 4'b0000 || b_out_valid !== 1'b1 || b_out_chan !== 2'd3) begin
            errors++;
            $display("FAIL mid_inrst: got ready=%b valid=%b chan=%0d expected 0000/1/3", b_in_ready, b_out_valid, b_out_chan);
        end
        next_cycle();
        rst = 1'b0;
        sb.push_back('{chan: 2'd0, data: 16'h0B00, last: 1'b1});
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 16'h0000 || b_out_chan !== 2'd0 || b_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_after: got valid=%b data=%h chan=%0d ready=%b expected 0/0000/0/0001",
                     b_out_valid, b_out_data, b_out_chan, b_in_ready);
        end
        next_cycle();
        b_in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_first: got valid=%b expected 1", b_out_valid);
        end else begin
            exp_t e = sb.pop_front();
            if (b_out_chan !== e.chan || b_out_data !== e.data || b_out_last !== e.last) begin
                errors++;
                $display("FAIL mid_word: got %0d/%h/%b expected %0d/%h/%b", b_out_chan, b_out_data, b_out_last, e.chan, e.data, e.last);
            end
        end
        sb.delete();
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr_nolock();
        test_lock_packet();
        test_stall();
        test_wrap_sel3();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
